// File: rtl/cl_seq_pkg.sv
// cl_seq_pkg: shared types and constants for the bit-serial cl sequencer.
package cl_seq_pkg;
    localparam int CL_SEL_W = 2;
    localparam int CL_SEQ_DEF_WIDTH = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;
endpackage

// File: rtl/cl_bit_serial_seq.sv
// cl_bit_serial_seq: steps the 1-bit cl cell across WIDTH-bit operands, LSB first, behind valid/ready handshakes.
module cl_bit_serial_seq
    import cl_seq_pkg::*;
#(
    parameter int WIDTH = CL_SEQ_DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [CL_SEL_W-1:0] in_s,
    output logic                cl_a,
    output logic                cl_b,
    output logic [CL_SEL_W-1:0] cl_s,
    input  logic                cl_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic                busy
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    seq_state_t state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, res;
    logic [CL_SEL_W-1:0] s_reg;
    logic [IW-1:0] idx;
    logic accept, deliver, last;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;
    assign last    = idx == LAST;
    assign out_result = res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE) ? (accept ? RUN : IDLE) :
                    (state == RUN)  ? (last ? DONE : RUN) :
                                      (deliver ? IDLE : DONE);
    end

    // in_ready is gated by rst so nothing looks acceptable while held in reset
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = state == DONE;
        busy      = state != IDLE;
        cl_a      = (state == RUN) && a_reg[idx];
        cl_b      = (state == RUN) && b_reg[idx];
        cl_s      = (state == RUN) ? s_reg : '0;
    end

    // The result register is cleared on delivery so out_result reads zero in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            idx   <= '0;
            res   <= '0;
        end else if (accept) begin
            a_reg <= in_a;
            b_reg <= in_b;
            s_reg <= in_s;
            idx   <= '0;
            res   <= '0;
        end else if (state == RUN) begin
            res[idx] <= cl_out;
            idx      <= last ? idx : idx + 1'b1;
        end else if (deliver) begin
            res <= '0;
        end
    end
endmodule

// File: tb/tb_cl_bit_serial_seq.sv
// tb_cl_bit_serial_seq: randomized and directed checks of the sequencer against an XOR cell stub.
module tb_cl_bit_serial_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic [3:0] in_a = '0, in_b = '0;
    logic [1:0] in_s = '0;
    logic cl_a, cl_b, cl_out;
    logic [1:0] cl_s;
    logic out_valid, out_ready = 1'b0, busy;
    logic [3:0] out_result;

    logic in_valid1 = 1'b0, in_ready1;
    logic [0:0] in_a1 = '0, in_b1 = '0;
    logic [1:0] in_s1 = '0;
    logic cl_a1, cl_b1, cl_out1;
    logic [1:0] cl_s1;
    logic out_valid1, out_ready1 = 1'b0, busy1;
    logic [0:0] out_result1;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign cl_out  = cl_a ^ cl_b;
    assign cl_out1 = cl_a1 ^ cl_b1;

    cl_bit_serial_seq #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_s(in_s),
        .cl_a(cl_a), .cl_b(cl_b), .cl_s(cl_s), .cl_out(cl_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .busy(busy)
    );

    cl_bit_serial_seq #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_s(in_s1),
        .cl_a(cl_a1), .cl_b(cl_b1), .cl_s(cl_s1), .cl_out(cl_out1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_result(out_result1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: rdy=%b vld=%b busy=%b expected 0 0 0", in_ready, out_valid, busy);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, busy, out_result, cl_a, cl_b, cl_s} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_idle: rdy=%b vld=%b busy=%b res=%b cl=%b%b%b expected 1 0 0 0000 0000",
                     in_ready, out_valid, busy, out_result, cl_a, cl_b, cl_s);
        end
    endtask

    task automatic test_single_op();
        logic [3:0] a = 4'b1010, b = 4'b0110;
        logic [1:0] exp_ab [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
        out_ready = 1'b1;
        in_a = a; in_b = b; in_s = 2'b01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({cl_a, cl_b} !== exp_ab[i] || cl_s !== 2'b01 || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_run[%0d]: ab=%b%b s=%b vld=%b rdy=%b busy=%b expected ab=%b s=01 0 0 1",
                         i, cl_a, cl_b, cl_s, out_valid, in_ready, busy, exp_ab[i]);
            end
            tick();
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_result !== 4'b1100 || {cl_a, cl_b, cl_s} !== 4'b0) begin
            n_fail++;
            $display("FAIL single_done: vld=%b res=%b cl=%b%b%b expected 1 1100 0000", out_valid, out_result, cl_a, cl_b, cl_s);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_result !== 4'b0) begin
            n_fail++;
            $display("FAIL single_idle: vld=%b rdy=%b busy=%b res=%b expected 0 1 0 0000", out_valid, in_ready, busy, out_result);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_a = 4'b1010; in_b = 4'b0110; in_s = 2'b01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_result !== 4'b1100 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: vld=%b res=%b rdy=%b busy=%b expected 1 1100 0 1",
                         i, out_valid, out_result, in_ready, busy);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: vld=%b rdy=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_input_while_busy();
        out_ready = 1'b1;
        in_a = 4'b1010; in_b = 4'b0110; in_s = 2'b01; in_valid = 1'b1;
        tick();
        in_a = 4'b1111; in_b = 4'b0000; in_s = 2'b11;
        repeat (4) tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_result !== 4'b1100) begin
            n_fail++;
            $display("FAIL busy_ignore: vld=%b res=%b expected 1 1100", out_valid, out_result);
        end
        tick();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_idle: rdy=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || cl_s !== 2'b11) begin
            n_fail++;
            $display("FAIL busy_accept2: busy=%b s=%b expected 1 11", busy, cl_s);
        end
        repeat (4) tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_result !== 4'b1111) begin
            n_fail++;
            $display("FAIL busy_second: vld=%b res=%b expected 1 1111", out_valid, out_result);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        in_a = 4'b1010; in_b = 4'b0110; in_s = 2'b01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, busy, in_ready, cl_a, cl_b, cl_s, out_result} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: vld=%b busy=%b rdy=%b cl=%b%b%b res=%b expected all 0",
                     out_valid, busy, in_ready, cl_a, cl_b, cl_s, out_result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_pulse[%0d]: vld=%b busy=%b expected 0 0", i, out_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] a, b, exp_res;
        logic [1:0] s;
        int hold;
        for (int n = 0; n < 20; n++) begin
            a = 4'($urandom); b = 4'($urandom); s = 2'($urandom);
            exp_res = a ^ b;
            out_ready = 1'b0;
            in_a = a; in_b = b; in_s = s; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            in_a = 4'($urandom); in_b = 4'($urandom); in_s = 2'($urandom);
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (cl_a !== a[i] || cl_b !== b[i] || cl_s !== s || out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_run[%0d.%0d]: ab=%b%b s=%b vld=%b expected ab=%b%b s=%b vld=0",
                             n, i, cl_a, cl_b, cl_s, out_valid, a[i], b[i], s);
                end
                tick();
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) tick();
            out_ready = 1'b1;
            n_tests++;
            if (out_valid !== 1'b1 || out_result !== exp_res) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: vld=%b res=%h expected 1 %h", n, out_valid, out_result, exp_res);
            end
            tick();
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_idle[%0d]: vld=%b rdy=%b expected 0 1", n, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_width1();
        out_ready1 = 1'b0;
        in_a1 = 1'b1; in_b1 = 1'b0; in_s1 = 2'b10; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        n_tests++;
        if (cl_a1 !== 1'b1 || cl_b1 !== 1'b0 || cl_s1 !== 2'b10 || busy1 !== 1'b1 || out_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_run: ab=%b%b s=%b busy=%b vld=%b expected 10 10 1 0", cl_a1, cl_b1, cl_s1, busy1, out_valid1);
        end
        tick();
        n_tests++;
        if (out_valid1 !== 1'b1 || out_result1 !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_done: vld=%b res=%b expected 1 1", out_valid1, out_result1);
        end
        out_ready1 = 1'b1;
        tick();
        n_tests++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_idle: vld=%b rdy=%b expected 0 1", out_valid1, in_ready1);
        end
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        n_tests++;
        if (busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_reaccept: busy=%b expected 1", busy1);
        end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_input_while_busy();
        test_reset_mid_run();
        test_random();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cl_bit_serial_seq.md
Name: cl_bit_serial_seq

Overview:
- Bit-serial sequencer that sits around the team's 1-bit logic cell `cl`. It is upstream of the cell, driving `cl_a`, `cl_b` and `cl_s`, and downstream of it, capturing `cl_out`.
- It accepts a WIDTH-bit operand pair plus a 2-bit select through a valid/ready handshake.
- It steps the cell one bit per clock, LSB first, and assembles the WIDTH-bit result.
- The result is presented on a valid/ready output handshake, so a single `cl` instance serves as a full-width logic unit of the 4-bit ALU.

Parameters:
- WIDTH, default 4: operand/result width in bits. Legal range is 1 and above.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair and select are valid.
- in_ready  output  1  block can accept a new operation.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_s  input  2  operation select, forwarded unchanged to the cell.
- cl_a  output  1  current bit of A to the cell.
- cl_b  output  1  current bit of B to the cell.
- cl_s  output  2  latched select to the cell.
- cl_out  input  1  cell result bit; treated as combinational from `cl_a`/`cl_b`/`cl_s`.
- out_valid  output  1  `out_result` holds a complete result.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  assembled result, LSB first.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, deassert sampled on clk):
  - state = IDLE, bit index = 0.
  - `a_reg`, `b_reg`, `s_reg` and the result register are cleared.
  - `out_valid` = 0, `busy` = 0, `cl_a` = `cl_b` = 0, `cl_s` = 2'b00.
  - `in_ready` = 0 while `rst` is high.
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` && `in_ready`: latch `in_a`, `in_b`, `in_s`; clear index and result register; go to RUN.
  - `in_valid` low: stay in IDLE. Input values are ignored outside the accept cycle.
- RUN:
  - `cl_a` = `a_reg[idx]`, `cl_b` = `b_reg[idx]`, `cl_s` = `s_reg`.
  - Each edge writes `result[idx]` = `cl_out` and increments idx.
  - The edge that writes `idx` = WIDTH-1 moves to DONE.
  - `in_ready` = 0 and `out_valid` = 0 throughout.
- DONE:
  - `out_valid` = 1; `out_result` is held stable.
  - `cl_a`, `cl_b`, `cl_s` are driven to 0.
  - On `out_valid` && `out_ready`: go to IDLE.
  - `out_ready` low: hold indefinitely (backpressure). No bits are lost or recomputed.
- Latency and throughput:
  - Accept edge at cycle T; result bits are captured at edges T+1 through T+WIDTH.
  - `out_valid` rises after edge T+WIDTH.
  - With `out_ready` held high, the output handshake completes at edge T+WIDTH+1.
  - A new accept is possible at edge T+WIDTH+2 at the earliest; there is no overlap of accept and deliver.
- WIDTH = 1: RUN lasts exactly one cycle.
- Index counter width is max(1, clog2(WIDTH)). The index never wraps; DONE is entered at WIDTH-1.
- `out_result` is zero in IDLE, holds partial bits in RUN, and is frozen in DONE. Consumers qualify it only with `out_valid`.
- `in_valid` asserted during RUN or DONE: ignored (`in_ready` = 0). The upstream holds its data per the handshake rule.
- Reset mid-RUN or mid-DONE: the operation is aborted and the result discarded. All outputs return to reset values immediately, independent of clk.
- `busy` = (state != IDLE).

Decomposition:
- Package `cl_seq_pkg`:
  - state enum type (IDLE/RUN/DONE).
  - constant `CL_SEL_W` = 2.
  - default WIDTH constant (4).
- No sub-module inside the block. The `cl` cell is instantiated alongside it at the ALU level, not inside.
- The index counter and the FSM live in this module.

Test Plan:
- Bench stub for all scenarios: `cl_out` = `cl_a` ^ `cl_b`, combinational.
- Reset then idle: after `rst` deassert → `in_ready` = 1, `out_valid` = 0, `busy` = 0, `out_result` = 0000, `cl_*` = 0.
- Single op, `out_ready` = 1: `in_a` = 1010, `in_b` = 0110, `in_s` = 01, `in_valid` for 1 cycle → `cl_s` = 01 for 4 cycles; `cl_a`/`cl_b` sequence (0,0),(1,1),(0,1),(1,0); `out_valid` for 1 cycle with `out_result` = 1100; back in IDLE at T+6.
- Backpressure: same op with `out_ready` = 0 for 10 cycles → `out_valid` = 1 and `out_result` = 1100 stable for all 10 cycles, `in_ready` = 0. Raise `out_ready` → one handshake, then IDLE.
- Input while busy: `in_valid` held high with `in_a` = 1111, `in_b` = 0000 during RUN → ignored; result still 1100. That new op is accepted on the first IDLE cycle and yields 1111.
- Reset mid-RUN: assert `rst` after 2 RUN cycles → `out_valid` = 0, `busy` = 0, `cl_*` = 0 immediately. No `out_valid` pulse follows reset release.
- WIDTH = 1 instance: `in_a` = 1, `in_b` = 0 → `out_valid` after edge T+1 with `out_result` = 1. Next accept possible at T+3.
